// File: rtl/mtx_pkg.sv
// Shared definitions for the matrix link framing: sync byte, header field
// positions, receive FSM state type and header layout.
package mtx_pkg;

  // Header sync byte occupies the top 8 bits of the link word.
  localparam logic [7:0] MTX_SYNC_BYTE = 8'hA5;
  localparam int         MTX_SYNC_W    = 8;

  // Fixed low header fields.
  localparam int MTX_CH_MSB  = 15;
  localparam int MTX_CH_LSB  = 8;
  localparam int MTX_LEN_MSB = 7;
  localparam int MTX_LEN_LSB = 0;

  // Sync byte position depends on the link word width.
  function automatic int mtx_sync_msb(input int dw);
    return dw - 1;
  endfunction

  function automatic int mtx_sync_lsb(input int dw);
    return dw - MTX_SYNC_W;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } mtx_state_e;

  // Parsed header; len holds payload length minus one.
  typedef struct packed {
    logic [7:0] sync;
    logic [7:0] ch;
    logic [7:0] len;
  } mtx_hdr_t;

endpackage

// File: rtl/mrx_out_stage.sv
// Single-entry registered valid/ready stage carrying data, channel and last.
// Accepts a new entry whenever empty or being drained in the same cycle, so
// it sustains one word per cycle with no bubble.
module mrx_out_stage #(
  parameter int DW = 32,
  parameter int CW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  input  logic [CW-1:0] i_ch,
  input  logic          i_last,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [CW-1:0] o_ch,
  output logic          o_last
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [CW-1:0] r_ch;
  logic          r_last;
  logic          w_load;

  assign o_ready = !r_valid || i_ready;
  assign w_load  = i_valid && o_ready;

  // Valid flag: set on load, cleared when the held entry is taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 r_valid <= 1'b0;
    else if (w_load)           r_valid <= 1'b1;
    else if (r_valid && i_ready) r_valid <= 1'b0;
  end

  // Payload registers only change on load, so they hold while stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
      r_ch   <= '0;
      r_last <= 1'b0;
    end else if (w_load) begin
      r_data <= i_data;
      r_ch   <= i_ch;
      r_last <= i_last;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ch    = r_ch;
  assign o_last  = r_last;

endmodule

// File: rtl/mrx_frame_rx.sv
// Framed link receiver: parses header words (sync, channel, length) and
// forwards payload words tagged with channel and last flag through a single
// registered output stage. Bad-sync headers are discarded; headers with an
// out-of-range channel have their payload dropped.
// Optional build macro MRX_STATS_EN adds frame_cnt / err_cnt counters.
module mrx_frame_rx
  import mtx_pkg::*;
#(
  parameter int  NUM_CH     = 32,
  parameter int  DATA_WIDTH = 32,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  test_mode_en,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_last,
  output logic                  sync_err,
  output logic                  ch_err
`ifdef MRX_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           err_cnt
`endif
);

  mtx_state_e      r_state, w_state_nxt;
  logic [7:0]      r_rem;
  logic [CH_W-1:0] r_ch;
  logic            r_sync_err, r_ch_err;

  mtx_hdr_t        w_hdr;
  logic            w_rx_xfer;
  logic            w_sync_ok;
  logic            w_ch_ok;
  logic            w_stg_ready;
  logic            w_ld;
  logic            w_hdr_xfer;
  logic            w_rem_zero;
  logic            w_unused;

  // Header fields are only meaningful when the FSM is in IDLE.
  assign w_hdr.sync = rx_data[mtx_sync_msb(DATA_WIDTH):mtx_sync_lsb(DATA_WIDTH)];
  assign w_hdr.ch   = rx_data[MTX_CH_MSB:MTX_CH_LSB];
  assign w_hdr.len  = rx_data[MTX_LEN_MSB:MTX_LEN_LSB];
  // Bits between the channel field and the sync byte carry nothing.
  assign w_unused   = ^rx_data;

  assign w_rx_xfer  = rx_valid && rx_ready;
  assign w_sync_ok  = (w_hdr.sync == MTX_SYNC_BYTE) || test_mode_en;
  assign w_ch_ok    = ({1'b0, w_hdr.ch} < 9'(NUM_CH));
  assign w_rem_zero = (r_rem == 8'd0);
  assign w_hdr_xfer = (r_state == ST_IDLE) && w_rx_xfer;

  // FSM state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state: header selects PAYLOAD or DROP, count exhaustion returns.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_xfer && w_sync_ok)
          w_state_nxt = w_ch_ok ? ST_PAYLOAD : ST_DROP;
      end
      ST_PAYLOAD, ST_DROP: begin
        if (w_rx_xfer && w_rem_zero) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: link ready and output-stage load strobe.
  always_comb begin
    rx_ready = 1'b0;
    w_ld     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DROP: rx_ready = 1'b1;
      ST_PAYLOAD: begin
        rx_ready = w_stg_ready;
        w_ld     = rx_valid && w_stg_ready;
      end
      default: rx_ready = 1'b0;
    endcase
    if (sys_rst) begin
      rx_ready = 1'b0;
      w_ld     = 1'b0;
    end
  end

  // Remaining-count: loaded from header length, decremented per payload word.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rem <= 8'd0;
    end else if (w_hdr_xfer && w_sync_ok) begin
      r_rem <= w_hdr.len;
    end else if (w_rx_xfer && (r_state != ST_IDLE) && !w_rem_zero) begin
      r_rem <= r_rem - 8'd1;
    end
  end

  // Channel latch for a frame that will be forwarded.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                              r_ch <= '0;
    else if (w_hdr_xfer && w_sync_ok && w_ch_ok) r_ch <= w_hdr.ch[CH_W-1:0];
  end

  // Error pulses, one cycle after the offending header transfer.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync_err <= 1'b0;
      r_ch_err   <= 1'b0;
    end else begin
      r_sync_err <= w_hdr_xfer && !w_sync_ok;
      r_ch_err   <= w_hdr_xfer && w_sync_ok && !w_ch_ok;
    end
  end

  assign sync_err = r_sync_err;
  assign ch_err   = r_ch_err;

  mrx_out_stage #(
    .DW (DATA_WIDTH),
    .CW (CH_W)
  ) u_out_stage (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_valid (w_ld),
    .o_ready (w_stg_ready),
    .i_data  (rx_data),
    .i_ch    (r_ch),
    .i_last  (w_rem_zero),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_ch    (out_ch),
    .o_last  (out_last)
  );

`ifdef MRX_STATS_EN
  logic [15:0] r_frame_cnt, r_err_cnt;

  // Completed-frame counter, saturating.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      r_frame_cnt <= 16'd0;
    else if (out_valid && out_ready && out_last && (r_frame_cnt != 16'hFFFF))
      r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  // Header error counter, saturating; the two pulses never coincide.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      r_err_cnt <= 16'd0;
    else if ((r_sync_err || r_ch_err) && (r_err_cnt != 16'hFFFF))
      r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_mrx_frame_rx.sv
// Scoreboard bench for mrx_frame_rx: frames are described at header/payload
// level, expected output words are queued on issue, a monitor pops and
// compares on every output handshake.
module tb_mrx_frame_rx;

  localparam int NUM_CH = 32;
  localparam int DW     = 32;
  localparam int CH_W   = $clog2(NUM_CH);

  logic            sys_clk = 1'b0;
  logic            sys_rst;
  logic            test_mode_en;
  logic            rx_valid;
  logic            rx_ready;
  logic [DW-1:0]   rx_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [CH_W-1:0] out_ch;
  logic            out_last;
  logic            sync_err;
  logic            ch_err;
`ifdef MRX_STATS_EN
  logic [15:0]     frame_cnt;
  logic [15:0]     err_cnt;
`endif

  mrx_frame_rx #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .test_mode_en (test_mode_en),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .out_last     (out_last),
    .sync_err     (sync_err),
    .ch_err       (ch_err)
`ifdef MRX_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [DW-1:0]   data;
    logic [CH_W-1:0] ch;
    logic            last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] pl[256];
  int checks = 0, errors = 0;
  int exp_sync = 0, exp_ch = 0, seen_sync = 0, seen_ch = 0;
  int good_since_rst = 0, errs_since_rst = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by test
  bit chk_rdy_hi = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] hdr(input logic [7:0] s, input logic [7:0] c, input logic [7:0] l);
    logic [DW-1:0] h;
    h = '0;
    h[DW-1 -: 8] = s;
    h[15:8] = c;
    h[7:0] = l;
    return h;
  endfunction

  // Downstream ready generator.
  always @(posedge sys_clk) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: scoreboard pop, hold-while-stalled check, error pulse counting.
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic [CH_W-1:0] hold_c;
  logic          hold_l;
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_word", {out_data, 8'(out_ch), 8'(out_last)}, {hold_d, 8'(hold_c), 8'(hold_l)});
      end
      if (chk_rdy_hi && rx_valid) chk("rx_ready_high", 64'(rx_ready), 64'd1);
      if (sync_err) seen_sync++;
      if (ch_err)   seen_ch++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(out_data), 64'hDEAD_0000_0000);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_ch",   64'(out_ch),   64'(e.ch));
          chk("out_last", 64'(out_last), 64'(e.last));
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_c = out_ch;
      hold_l = out_last;
    end
  end

  // Present one word and wait for its link transfer; leaves rx_valid high.
  task automatic send(input logic [DW-1:0] w);
    int  n;
    bit  hs;
    rx_valid = 1'b1;
    rx_data  = w;
    n = 0;
    forever begin
      @(negedge sys_clk);
      hs = rx_ready;
      @(posedge sys_clk);
      #1;
      if (hs) break;
      n++;
      if (n > 1000) begin
        errors++;
        $display("FAIL send_timeout: rx_ready low for %0d cycles, expected a transfer", n);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
      end
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Issue one frame using pl[0..len]; expectations come from header rules.
  task automatic run_frame(input logic [7:0] s, input int c, input int len, input bit tm, input bit gaps);
    bit good;
    test_mode_en = tm;
    if ((s != 8'hA5) && !tm) begin
      exp_sync++;
      errs_since_rst++;
      send(hdr(s, 8'(c), 8'(len)));
      idle(1);
      return;
    end
    good = (c < NUM_CH);
    if (!good) begin
      exp_ch++;
      errs_since_rst++;
    end
    send(hdr(s, 8'(c), 8'(len)));
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      if (good) exp_q.push_back('{data: pl[i], ch: CH_W'(c), last: (i == len)});
      send(pl[i]);
    end
    if (good) good_since_rst++;
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rx_valid = 1'b0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    idle(2);
  endtask

  initial begin
    sys_rst      = 1'b1;
    test_mode_en = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = '0;
    out_ready    = 1'b1;
    #2;
    chk("rst_rx_ready",  64'(rx_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_ch",    64'(out_ch),    64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_errs",      64'({sync_err, ch_err}), 64'd0);
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    idle(1);

    // Basic frame, full throughput, 1-cycle latency.
    rdy_mode = 0;
    chk_rdy_hi = 1;
    test_mode_en = 1'b0;
    send(hdr(8'hA5, 8'd3, 8'd2));
    chk("hdr_no_output", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] w;
      w = DW'((i + 1) * 'h11);
      exp_q.push_back('{data: w, ch: CH_W'(3), last: (i == 2)});
      send(w);
      chk("lat1_valid", 64'(out_valid), 64'd1);
      chk("lat1_data",  64'(out_data),  64'(w));
    end
    drain();
    chk_rdy_hi = 0;

    // Same frame with a 5-cycle downstream stall after the first payload.
    send(hdr(8'hA5, 8'd3, 8'd2));
    exp_q.push_back('{data: 'h11, ch: CH_W'(3), last: 1'b0});
    send('h11);
    rdy_mode = 2;
    out_ready = 1'b0;
    rx_data = 'h22;
    repeat (5) begin
      @(negedge sys_clk);
      chk("stall_rx_ready", 64'(rx_ready), 64'd0);
      chk("stall_data",     64'(out_data), 64'h11);
      @(posedge sys_clk); #1;
    end
    out_ready = 1'b1;
    exp_q.push_back('{data: 'h22, ch: CH_W'(3), last: 1'b0});
    send('h22);
    exp_q.push_back('{data: 'h33, ch: CH_W'(3), last: 1'b1});
    send('h33);
    rdy_mode = 0;
    drain();

    // Bad sync, then good frame; then bad sync accepted in test mode.
    pl[0] = 'h77;
    run_frame(8'h5A, 1, 0, 1'b0, 1'b0);
    run_frame(8'hA5, 1, 0, 1'b0, 1'b0);
    drain();
    chk("sync_err_cnt_a", 64'(seen_sync), 64'(exp_sync));
    pl[0] = 'h88;
    run_frame(8'h5A, 1, 0, 1'b1, 1'b0);
    drain();
    chk("sync_err_cnt_b", 64'(seen_sync), 64'(exp_sync));

    // Out-of-range channel with two payload words, then a good frame.
    pl[0] = 'hAAAA; pl[1] = 'hBBBB;
    run_frame(8'hA5, 40, 1, 1'b0, 1'b0);
    pl[0] = 'h1234; pl[1] = 'h5678;
    run_frame(8'hA5, 31, 1, 1'b0, 1'b0);
    drain();
    chk("ch_err_cnt", 64'(seen_ch), 64'(exp_ch));

    // Maximum length frame under random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 256; i++) pl[i] = $urandom;
    run_frame(8'hA5, 0, 255, 1'b0, 1'b0);
    drain();

    // Randomised frames.
    for (int f = 0; f < 40; f++) begin
      logic [7:0] s;
      int len;
      s = ($urandom_range(0, 9) == 0) ? 8'h5A : 8'hA5;
      len = $urandom_range(0, 7);
      for (int i = 0; i <= len; i++) pl[i] = $urandom;
      run_frame(s, $urandom_range(0, 39), len, ($urandom_range(0, 4) == 0), 1'b1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    drain();
    chk("sync_err_cnt_r", 64'(seen_sync), 64'(exp_sync));
    chk("ch_err_cnt_r",   64'(seen_ch),   64'(exp_ch));
`ifdef MRX_STATS_EN
    chk("frame_cnt", 64'(frame_cnt), 64'(good_since_rst));
    chk("err_cnt",   64'(err_cnt),   64'(errs_since_rst));
`endif

    // Reset in the middle of a long frame.
    rdy_mode = 0;
    test_mode_en = 1'b0;
    send(hdr(8'hA5, 8'd0, 8'hFF));
    for (int i = 0; i < 100; i++) begin
      logic [DW-1:0] w;
      w = $urandom;
      exp_q.push_back('{data: w, ch: '0, last: 1'b0});
      send(w);
    end
    sys_rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_rx_ready",  64'(rx_ready),  64'd0);
    chk("midrst_pending",   64'(exp_q.size()), 64'd1);
    exp_q.delete();
    good_since_rst = 0;
    errs_since_rst = 0;
    rx_valid = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    idle(1);
    pl[0] = 'hCAFE; pl[1] = 'hBEEF;
    run_frame(8'hA5, 2, 1, 1'b0, 1'b0);
    drain();
    pl[0] = 'h0;
    run_frame(8'h00, 5, 0, 1'b0, 1'b0);
    drain();
    chk("sync_err_cnt_f", 64'(seen_sync), 64'(exp_sync));
`ifdef MRX_STATS_EN
    chk("frame_cnt_post_rst", 64'(frame_cnt), 64'(good_since_rst));
    chk("err_cnt_post_rst",   64'(err_cnt),   64'(errs_since_rst));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mrx_frame_rx.md
Name: mrx_frame_rx

Overview:
Receive-side counterpart of the multi-channel transmitter. Accepts the framed word stream the transmitter emits (one header word, then payload words) and parses each header. Forwards payload words to one output stream tagged with channel index and last flag. Sits between the link interface and the per-channel sinks in the matrix subsystem.

Parameters:
NUM_CH, 32, number of logical channels; legal channel ids are 0..NUM_CH-1; 1..256.
DATA_WIDTH, 32, word width of link and output data; must be >=24.

Ports:
sys_clk  input  1  system clock; all logic on rising edge.
sys_rst  input  1  asynchronous, active-high reset.
test_mode_en  input  1  when high, header sync-byte check is bypassed.
rx_valid  input  1  link word valid.
rx_ready  output  1  block accepts link word this cycle.
rx_data  input  DATA_WIDTH  link word (header or payload).
out_valid  output  1  output word valid.
out_ready  input  1  downstream accepts output word.
out_data  output  DATA_WIDTH  payload word.
out_ch  output  $clog2(NUM_CH) (min 1)  channel id of out_data.
out_last  output  1  final payload word of frame.
sync_err  output  1  one-cycle pulse: header word with bad sync byte discarded.
ch_err  output  1  one-cycle pulse: header with channel id >= NUM_CH.

Behaviour:
- Header word fields:
  - [DATA_WIDTH-1:DATA_WIDTH-8] = sync byte 8'hA5.
  - [15:8] = channel id.
  - [7:0] = payload length minus 1 (1..256 words).
  - Other bits ignored.
- Transfer rules:
  - Link transfer occurs when rx_valid && rx_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_valid, once high, holds with out_data/out_ch/out_last stable until accepted.
- Reset values: rx_ready 0 while sys_rst high, out_valid 0, out_data 0, out_ch 0, out_last 0, sync_err 0, ch_err 0, state IDLE, counters 0.
- rx_ready depends on state:
  - IDLE and DROP: rx_ready = 1.
  - PAYLOAD: rx_ready = !out_valid || out_ready. This gives a single registered output stage with full throughput and no bubble.
- FSM states are IDLE, PAYLOAD and DROP.
- IDLE, on link transfer:
  - Sync byte mismatch and test_mode_en=0: discard word, pulse sync_err next cycle, stay IDLE.
  - Otherwise, channel id >= NUM_CH: load remaining-count = len field, pulse ch_err, go to DROP.
  - Otherwise: latch channel id, load remaining-count = len field, go to PAYLOAD.
  - Headers produce no output word.
- PAYLOAD, on link transfer:
  - Register word to output with out_valid=1, out_ch = latched id, out_last = (remaining-count==0).
  - If remaining-count==0, go to IDLE; else decrement.
- DROP, on link transfer:
  - Discard word.
  - If remaining-count==0, go to IDLE; else decrement.
- Latency: payload word appears on out_* the cycle after its link transfer.
- Simultaneous events: in the same cycle, an output handshake and a new link transfer load the next word with no gap.
- Back-to-back frames: the header immediately following a last payload word is accepted in the next cycle.
- Remaining-count is 8 bits. len field 8'hFF gives 256 payload words; no wrap beyond 0.
- Reset mid-frame: frame is abandoned, any pending output word is lost, FSM returns to IDLE. After reset the first accepted word is treated as a header.

Optional Feature:
- Macro MRX_STATS_EN.
- Defined: adds outputs frame_cnt[15:0] and err_cnt[15:0], both reset 0.
  - frame_cnt increments on each out_last output handshake.
  - err_cnt increments on each sync_err or ch_err pulse.
  - Both saturate at 16'hFFFF.
- Not defined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package mtx_pkg holds:
  - MTX_SYNC_BYTE = 8'hA5.
  - Header field bit-position constants (sync MSB/LSB, ch 15:8, len 7:0).
  - Typedef for the state enum (IDLE, PAYLOAD, DROP).
  - Typedef for the header struct.
- Natural sub-module: mrx_out_stage, the single-entry registered valid/ready stage carrying data, ch and last. It is reusable by the transmitter's output side.

Test Plan:
- Header A5_03_02 (ch 3, len 3) then payload 11,22,33 with out_ready=1: three outputs on ch 3 at 1-cycle latency, out_last only on 33; rx_ready constant 1.
- Same frame with out_ready held low for 5 cycles after first payload: out_data holds 11, rx_ready=0 in PAYLOAD, no word lost or duplicated after release.
- Header 5A_01_00 with test_mode_en=0: sync_err pulses once, no output, next A5_01_00 + word 77 yields out_ch=1, out_last=1, data 77. Repeat with test_mode_en=1: first header accepted.
- Header A5_28_01 (ch 40 >= 32) with two payload words: ch_err pulses, both words consumed with no output, following valid frame passes intact.
- len=8'hFF frame on ch 0: exactly 256 outputs, out_last on the 256th, then IDLE. Assert sys_rst after payload word 100 of a second frame: out_valid 0 immediately, next word is parsed as header.
- With MRX_STATS_EN: after 3 good frames and 2 errored headers, frame_cnt=3 and err_cnt=2.
